// File: rtl/morse_code_decoder.sv
// Morse receive decoder: samples a synchronised mark/space line once per unit at
// mid-unit and recovers the A-H letter index, with valid/error strobes.
module morse_code_decoder #(
  parameter int unsigned UNIT_COUNT = 25_000_000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       morseBit,
  output logic [2:0] letterOut,
  output logic       letterValid,
  output logic       errorFlag
);

  typedef enum logic [2:0] {IDLE, MARK, SPACE, DECODE, ERROR} stateT;

  stateT            state, stateNext;
  logic             syncA, s, sPrev;
  logic [1:0]       primed;
  logic             armed, riseHeld;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       markLen, markNext, spaceLen, spaceNext, symCnt, symCntNext;
  logic [3:0]       sym, symNext;
  logic             rise, go, tick, match;
  logic [2:0]       matchIdx;

  // armed stays low until a genuine low level has passed the synchroniser,
  // so a line already high out of reset cannot start a letter
  assign rise = s & ~sPrev & armed;
  assign go   = rise | riseHeld;
  assign tick = (state != IDLE) && (cnt == '0);

  // symbols shift in MSB-first as 1=dash, 0=dot
  always_comb begin
    match    = 1'b1;
    matchIdx = '0;
    case ({symCnt, sym})
      7'b010_0001: matchIdx = 3'd0;
      7'b100_1000: matchIdx = 3'd1;
      7'b100_1010: matchIdx = 3'd2;
      7'b011_0100: matchIdx = 3'd3;
      7'b001_0000: matchIdx = 3'd4;
      7'b100_0010: matchIdx = 3'd5;
      7'b011_0110: matchIdx = 3'd6;
      7'b100_0000: matchIdx = 3'd7;
      default:     match    = 1'b0;
    endcase
  end

  always_comb begin
    stateNext  = state;
    markNext   = markLen;
    spaceNext  = spaceLen;
    symCntNext = symCnt;
    symNext    = sym;
    case (state)
      IDLE: if (go) begin
        stateNext  = MARK;
        markNext   = '0;
        symCntNext = '0;
        symNext    = '0;
      end
      MARK: if (tick) begin
        if (s) begin
          if (markLen == 3'd3) stateNext = ERROR;
          else                 markNext  = markLen + 3'd1;
        end else if ((markLen != 3'd1 && markLen != 3'd3) || symCnt == 3'd4) begin
          stateNext = ERROR;
        end else begin
          symNext    = {sym[2:0], markLen == 3'd3};
          symCntNext = symCnt + 3'd1;
          spaceNext  = 3'd1;
          stateNext  = SPACE;
        end
      end
      SPACE: if (tick) begin
        if (s) begin
          if (spaceLen == 3'd1) begin
            stateNext = MARK;
            markNext  = 3'd1;
          end else begin
            stateNext = ERROR;
          end
        end else if (spaceLen == 3'd2) begin
          stateNext = DECODE;
        end else begin
          spaceNext = spaceLen + 3'd1;
        end
      end
      DECODE: stateNext = IDLE;
      ERROR: if (tick) begin
        if (s)                      spaceNext = '0;
        else if (spaceLen == 3'd2)  stateNext = IDLE;
        else                        spaceNext = spaceLen + 3'd1;
      end
      default: stateNext = IDLE;
    endcase
    if (stateNext == ERROR && state != ERROR) spaceNext = '0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      syncA       <= 1'b0;
      s           <= 1'b0;
      sPrev       <= 1'b0;
      primed      <= '0;
      armed       <= 1'b0;
      riseHeld    <= 1'b0;
      cnt         <= '0;
      markLen     <= '0;
      spaceLen    <= '0;
      symCnt      <= '0;
      sym         <= '0;
      letterOut   <= '0;
      letterValid <= 1'b0;
      errorFlag   <= 1'b0;
    end else begin
      syncA    <= morseBit;
      s        <= syncA;
      sPrev    <= s;
      primed   <= {primed[0], 1'b1};
      armed    <= armed | (primed[1] & ~s);
      // an edge landing in the DECODE cycle is replayed into IDLE
      riseHeld <= (state == DECODE) & rise;
      if (state == IDLE) begin
        if (go) cnt <= CNT_W'(UNIT_COUNT / 2 - 1);
      end else if (cnt == '0) begin
        cnt <= CNT_W'(UNIT_COUNT - 1);
      end else begin
        cnt <= cnt - 1'b1;
      end
      state       <= stateNext;
      markLen     <= markNext;
      spaceLen    <= spaceNext;
      symCnt      <= symCntNext;
      sym         <= symNext;
      letterValid <= (state == DECODE) & match;
      errorFlag   <= ((state == DECODE) & ~match) | (stateNext == ERROR && state != ERROR);
      if (state == DECODE && match) letterOut <= matchIdx;
    end
  end

endmodule

// File: tb/tb_morse_code_decoder.sv
// Bench for morse_code_decoder: unit-level stimulus, a run-length letter model
// feeding an expected-event queue, and a per-cycle compare process.
module tb_morse_code_decoder;

  logic       Clock, Reset, morseBit;
  logic [2:0] letterOut;
  logic       letterValid, errorFlag;

  morse_code_decoder #(.UNIT_COUNT(4), .CNT_W(32)) dut (
    .Clock(Clock), .Reset(Reset), .morseBit(morseBit),
    .letterOut(letterOut), .letterValid(letterValid), .errorFlag(errorFlag)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    startCyc = 0;
  int    latency  = -1;
  bit    latArm   = 0;
  int    expHeld  = 0;
  int    nValid   = 0;
  int    nErr     = 0;
  int    expQ[$];
  bit    units[$];
  string alpha[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int lookup(input string code);
    for (int k = 0; k < 8; k++) if (alpha[k] == code) return k;
    return 8;
  endfunction

  // Parses whole units into letters by run lengths; 8 denotes an error event.
  function automatic void runModel();
    int    n = units.size();
    int    i = 0;
    int    l, g;
    bit    isBad;
    string code;
    while (i < n) begin
      while (i < n && units[i] == 1'b0) i++;
      if (i >= n) break;
      code  = "";
      isBad = 0;
      forever begin
        l = 0;
        while (i < n && units[i] == 1'b1) begin l++; i++; end
        if (i >= n) return;
        if (l == 2 || l >= 4 || code.len() == 4) begin isBad = 1; break; end
        if (l == 1) code = {code, "."};
        else        code = {code, "-"};
        g = 0;
        while (i < n && units[i] == 1'b0 && g < 3) begin g++; i++; end
        if (g == 3) break;
        if (i >= n) return;
        if (g == 2) begin isBad = 1; break; end
      end
      if (isBad) begin
        expQ.push_back(8);
        g = 0;
        while (i < n && g < 4) begin
          if (units[i] == 1'b0) g++;
          else                  g = 0;
          i++;
        end
      end else begin
        expQ.push_back(lookup(code));
      end
    end
  endfunction

  task automatic addLetter(input string p);
    for (int k = 0; k < p.len(); k++) begin
      if (p[k] == "-") repeat (3) units.push_back(1'b1);
      else             units.push_back(1'b1);
      if (k != p.len() - 1) units.push_back(1'b0);
    end
  endtask

  task automatic addGap(input int n);
    repeat (n) units.push_back(1'b0);
  endtask

  task automatic sendUnits();
    runModel();
    foreach (units[k]) begin
      morseBit = units[k];
      repeat (4) @(negedge Clock);
    end
    units.delete();
  endtask

  always @(posedge Clock) begin
    int e;
    #1;
    chk("noCoincide", int'(letterValid & errorFlag), 0);
    if (letterValid || errorFlag) begin
      if (letterValid) nValid++;
      if (errorFlag)   nErr++;
      if (expQ.size() == 0) begin
        chk("unexpectedStrobe", errorFlag ? 8 : int'(letterOut), -1);
      end else begin
        e = expQ.pop_front();
        chk("strobe", errorFlag ? 8 : int'(letterOut), e);
        if (e < 8) expHeld = e;
      end
      if (letterValid && latArm) begin
        latArm  = 0;
        latency = cyc - startCyc;
      end
    end
    chk("letterHeld", int'(letterOut), expHeld);
  end

  initial begin
    int v0, e0;
    Reset    = 1'b1;
    morseBit = 1'b0;

    // pin the model on literal vectors
    units = '{1, 0, 1, 1, 1, 0, 0, 0};
    runModel();
    chk("modelA", expQ.size() == 1 ? expQ[0] : -1, 0);
    expQ.delete(); units.delete();
    units = '{1, 1, 0, 0, 0, 0, 0};
    runModel();
    chk("modelBadMark", expQ.size() == 1 ? expQ[0] : -1, 8);
    expQ.delete(); units.delete();
    addLetter("-.-."); addGap(3); addLetter("...."); addGap(3);
    runModel();
    chk("modelCH", expQ.size() == 2 ? expQ[0] * 10 + expQ[1] : -1, 27);
    expQ.delete(); units.delete();

    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    chk("rstOut", int'(letterOut), 0);
    chk("rstValid", int'(letterValid), 0);
    chk("rstErr", int'(errorFlag), 0);
    repeat (8) @(negedge Clock);

    // 1: A with latency measurement
    units = '{1, 0, 1, 1, 1, 0, 0, 0};
    addGap(4);
    startCyc = cyc;
    latArm   = 1;
    sendUnits();
    chk("t1Latency", latency, 34);
    chk("t1Valid", nValid, 1);
    chk("t1Err", nErr, 0);
    chk("t1Letter", int'(letterOut), 0);
    chk("t1Queue", expQ.size(), 0);

    // 2: C then H with a 3-unit gap
    v0 = nValid; e0 = nErr;
    addLetter("-.-."); addGap(3); addLetter("...."); addGap(5);
    sendUnits();
    chk("t2Valid", nValid - v0, 2);
    chk("t2Err", nErr - e0, 0);
    chk("t2Letter", int'(letterOut), 7);
    chk("t2Queue", expQ.size(), 0);

    // 3: 2-unit mark, then E
    v0 = nValid; e0 = nErr;
    units = '{1, 1};
    addGap(6); addLetter("."); addGap(5);
    sendUnits();
    chk("t3Err", nErr - e0, 1);
    chk("t3Valid", nValid - v0, 1);
    chk("t3Letter", int'(letterOut), 4);
    chk("t3Queue", expQ.size(), 0);

    // 4: five dots, then G
    v0 = nValid; e0 = nErr;
    addLetter("....."); addGap(6); addLetter("--."); addGap(5);
    sendUnits();
    chk("t4Err", nErr - e0, 1);
    chk("t4Valid", nValid - v0, 1);
    chk("t4Letter", int'(letterOut), 6);
    chk("t4Queue", expQ.size(), 0);

    // 5: reset mid-B, then D
    v0 = nValid; e0 = nErr;
    units = '{1, 1, 1, 0, 1, 0};
    sendUnits();
    Reset   = 1'b1;
    expHeld = 0;
    @(negedge Clock);
    Reset = 1'b0;
    chk("t5RstOut", int'(letterOut), 0);
    chk("t5RstValid", int'(letterValid), 0);
    chk("t5RstErr", int'(errorFlag), 0);
    chk("t5NoStrobe", nValid + nErr - v0 - e0, 0);
    addGap(2); addLetter("-.."); addGap(5);
    sendUnits();
    chk("t5Valid", nValid - v0, 1);
    chk("t5Err", nErr - e0, 0);
    chk("t5Letter", int'(letterOut), 3);

    // 6: all eight letters back to back
    v0 = nValid; e0 = nErr;
    for (int k = 0; k < 8; k++) begin
      addLetter(alpha[k]);
      addGap(3);
    end
    addGap(3);
    sendUnits();
    chk("t6Valid", nValid - v0, 8);
    chk("t6Err", nErr - e0, 0);
    chk("t6Letter", int'(letterOut), 7);
    chk("t6Queue", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
